heap_pingpong_sched: RTL and testbench
======================================

# heap_pingpong_sched

Scheduler for the dual-bank (ping-pong) heapsort datapath. Accepts one `data_in` sample per rising edge of the `fs` strobe and writes it into the bank currently filling. It hands each full bank to the single shared sort engine through a start/done handshake, and tracks each bank until downstream drains it. It sits between the sample source and the dual-port heap RAM/sort engine, and owns all bank-state bookkeeping.

## Interface
- `LEVEL`, default 2: heap depth; bank size N = 2**(LEVEL+1)-1 (LEVEL=2 → N=7).
- `DW`, default 32: sample width.
- `AW`, default $clog2(N): RAM address width (derived, not overridden).
- `clk`, in, 1: single clock; everything is synchronous to its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `fs`, in, 1: sample strobe, synchronous to `clk`; the rising edge is detected internally.
- `en_rec_in`, in, 1: recording enable; sampled together with the `fs` edge.
- `data_in`, in, DW: sample value.
- `wr_en`, out, 1: one-cycle RAM write pulse.
- `wr_bank`, out, 1: bank being written.
- `wr_addr`, out, AW: write address.
- `wr_data`, out, DW: captured sample.
- `sort_start`, out, 1: one-cycle pulse that starts the sort engine.
- `sort_bank`, out, 1: bank given to the engine; held stable until `sort_done`.
- `sort_done`, in, 1: one-cycle pulse from the engine.
- `drain_done`, in, 2: per-bank pulse from downstream; the bank has been read out.
- `bank_ready`, out, 2: per-bank flag, high while that bank is SORTED.
- `fill_bank`, out, 1: bank currently selected for filling.
- `overrun`, out, 1: sticky flag; a sample was dropped.
- `drop_cnt`, out, 16: dropped-sample counter (see Configuration).

## Operation
- Per-bank FSM states: EMPTY → FILLING → FULL → SORTING → SORTED → EMPTY.
- Sample accept: `fs & ~fs_q & en_rec_in` while `fill_bank` is EMPTY or FILLING.
  - Effect: write at `wr_addr` = fill pointer; pointer increments modulo N.
  - The first accepted sample moves the bank EMPTY → FILLING.
- Write of address N-1: the bank becomes FULL and the pointer wraps to 0.
  - `fill_bank` toggles if the other bank is EMPTY, or receives `drain_done` in that same cycle (bypass).
  - Otherwise `fill_bank` stays on the FULL bank.
- A sample arriving while `fill_bank` is not EMPTY/FILLING is dropped:
  - no `wr_en`;
  - `overrun` set;
  - `drop_cnt` increments, saturating at 16'hFFFF.
- `en_rec_in` low: edges are ignored and the pointer holds; a partial fill is kept.
- Engine arbitration: when the engine is idle and a bank is FULL, issue `sort_start` and move that bank to SORTING.
  - If both banks are FULL, start the one that filled first; a one-bit order register records this.
- `sort_done` moves the SORTING bank to SORTED. The engine is idle again the next cycle.
- `sort_done` while no bank is SORTING is ignored.
- `drain_done[b]` moves bank b SORTED → EMPTY. In any other state it is ignored.
- `overrun` is cleared only by `rst`.

## Timing
- Reset values: every output is 0. All banks are EMPTY, the pointer is 0, the engine is idle. Reset applies immediately on `rst` assertion.
- `wr_en`, `wr_addr`, `wr_data`, `wr_bank` are registered. They are valid the cycle after the clock edge that first sees `fs`=1 with `fs_q`=0. `data_in` is captured at that same edge.
- `sort_start` rises the cycle after the bank's FULL state registers, or the cycle after `sort_done` frees the engine. It is 1 cycle wide.
- `bank_ready[b]` rises the cycle after `sort_done` and falls the cycle after `drain_done[b]`.
- Reset mid-sort aborts scheduling. The engine shares `rst` and is reset with this block.
- Minimum `fs` period: 2 `clk` cycles.

## Configuration
- `HEAP_SCHED_DROP_CNT_EN` defined: the 16-bit saturating `drop_cnt` counter is present.
- Not defined: the counter logic is absent and `drop_cnt` is tied to 0. `overrun` behaves identically in both cases.

## Structure
- Package `heap_sched_pkg`:
  - bank-state enum (EMPTY, FILLING, FULL, SORTING, SORTED);
  - N/AW derivation function of LEVEL;
  - DROP_CNT_W=16.
- Sub-module `heap_bank_fsm`, instantiated twice. Per-bank state with event inputs: first_wr, last_wr, start, done, drain.
- Top level holds the `fs` edge detector, fill pointer, fill-bank select, engine arbiter and order register.

## Test plan
- Reset, `en_rec_in`=1, LEVEL=2, samples 1..7 → seven `wr_en` pulses to bank 0 at addresses 0..6. `sort_start` with `sort_bank`=0 arrives one cycle after the 7th write; `fill_bank`=1.
- `sort_done` 20 cycles after start → `bank_ready`=2'b01 next cycle. The next 7 samples go to bank 1, addresses 0..6.
- Both banks filled, no `drain_done`, 8th further sample → no `wr_en`, `overrun`=1, `drop_cnt`=1 (with macro) or 0 (without).
- `drain_done[0]` in the same cycle as bank 1's 7th write → `fill_bank`=0, and the next sample is written to bank 0 address 0 with no drop.
- `en_rec_in`=0 for 3 `fs` edges after 4 writes → no `wr_en`, `wr_addr` holds. Re-enabling resumes at address 4.
- `rst` pulsed while bank 0 is SORTING → all outputs 0 immediately. A later `sort_done` is ignored.

Source files
------------

// File: rtl/heap_sched_pkg.sv
// Shared types and sizing helpers for the ping-pong heapsort scheduler.
package heap_sched_pkg;

   // Per-bank lifecycle: filled by the sample source, sorted by the engine,
   // then read out downstream before it can be refilled.
   typedef enum logic [2:0] {
      BS_EMPTY   = 3'd0,
      BS_FILLING = 3'd1,
      BS_FULL    = 3'd2,
      BS_SORTING = 3'd3,
      BS_SORTED  = 3'd4
   } bank_state_e;

   localparam int DROP_CNT_W = 16;

   // Number of nodes in a complete heap of the given depth.
   function automatic int heap_n(input int level);
      return (1 << (level + 1)) - 1;
   endfunction

   // Address width for one bank; never narrower than one bit.
   function automatic int heap_aw(input int level);
      int n;
      n = heap_n(level);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/heap_bank_fsm.sv
// State tracker for one heap bank. Events are single-cycle pulses from the
// scheduler; an event that does not apply to the current state is ignored.
module heap_bank_fsm
   import heap_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       first_wr_i,
   input  logic       last_wr_i,
   input  logic       start_i,
   input  logic       done_i,
   input  logic       drain_i,
   output logic [2:0] state_o
);

   bank_state_e state_q, state_d;

   // Next-state selection: each state listens only to the event that leaves it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BS_EMPTY: begin
            if (last_wr_i)       state_d = BS_FULL;
            else if (first_wr_i) state_d = BS_FILLING;
         end
         BS_FILLING: if (last_wr_i) state_d = BS_FULL;
         BS_FULL:    if (start_i)   state_d = BS_SORTING;
         BS_SORTING: if (done_i)    state_d = BS_SORTED;
         BS_SORTED:  if (drain_i)   state_d = BS_EMPTY;
         default:                   state_d = BS_EMPTY;
      endcase
   end

   // State register, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= BS_EMPTY;
      else       state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/heap_pingpong_sched.sv
// Ping-pong bank scheduler for the shared heapsort engine.
// Optional feature: define HEAP_SCHED_DROP_CNT_EN to build the 16-bit
// saturating drop counter; otherwise drop_cnt is tied to zero.
// Handshakes: sort_start is a one-cycle request; sort_bank holds until the
// engine answers with a one-cycle sort_done. drain_done[b] is a one-cycle
// notice that bank b has been read out.
module heap_pingpong_sched
   import heap_sched_pkg::*;
#(
   parameter  int LEVEL = 2,
   parameter  int DW    = 32,
   localparam int N     = heap_n(LEVEL),
   localparam int AW    = heap_aw(LEVEL)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fs,
   input  logic                  en_rec_in,
   input  logic [DW-1:0]         data_in,
   output logic                  wr_en,
   output logic                  wr_bank,
   output logic [AW-1:0]         wr_addr,
   output logic [DW-1:0]         wr_data,
   output logic                  sort_start,
   output logic                  sort_bank,
   input  logic                  sort_done,
   input  logic [1:0]            drain_done,
   output logic [1:0]            bank_ready,
   output logic                  fill_bank,
   output logic                  overrun,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   logic [1:0][2:0] st;
   logic            fs_q;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            fill_bank_q, fill_bank_d;
   logic            first_q, first_d;
   logic            wr_en_q, wr_bank_q;
   logic [AW-1:0]   wr_addr_q;
   logic [DW-1:0]   wr_data_q;
   logic            sort_start_q, sort_bank_q, overrun_q;

   logic            other, smp, fill_ok, do_wr, do_drop, is_last, other_free;
   logic            full0, full1, busy, start_any, pick;
   logic [1:0]      wr_evt, last_evt, start_evt, done_evt;

   // Sample acceptance, bank hand-over and engine arbitration decisions.
   always_comb begin
      other      = ~fill_bank_q;
      smp        = fs & ~fs_q & en_rec_in;
      fill_ok    = (st[fill_bank_q] == BS_EMPTY) || (st[fill_bank_q] == BS_FILLING);
      do_wr      = smp & fill_ok;
      do_drop    = smp & ~fill_ok;
      is_last    = do_wr && (ptr_q == LAST_ADDR);
      // A drain arriving on the same cycle frees the other bank just in time.
      other_free = (st[other] == BS_EMPTY) ||
                   ((st[other] == BS_SORTED) && drain_done[other]);

      full0      = (st[0] == BS_FULL);
      full1      = (st[1] == BS_FULL);
      busy       = (st[0] == BS_SORTING) || (st[1] == BS_SORTING);
      start_any  = ~busy & (full0 | full1);
      pick       = (full0 & full1) ? first_q : full1;

      ptr_d = ptr_q;
      if (do_wr) ptr_d = is_last ? '0 : ptr_q + 1'b1;
      fill_bank_d = (is_last && other_free) ? other : fill_bank_q;
      // Remember which bank completed first in case both end up waiting.
      first_d = (is_last && (st[other] != BS_FULL)) ? fill_bank_q : first_q;

      wr_evt    = {do_wr & fill_bank_q,       do_wr & ~fill_bank_q};
      last_evt  = {is_last & fill_bank_q,     is_last & ~fill_bank_q};
      start_evt = {start_any & pick,          start_any & ~pick};
      done_evt  = {sort_done & (st[1] == BS_SORTING),
                   sort_done & (st[0] == BS_SORTING)};
   end

   heap_bank_fsm u_bank0 (
      .clk_i(clk), .rst_i(rst),
      .first_wr_i(wr_evt[0]), .last_wr_i(last_evt[0]),
      .start_i(start_evt[0]), .done_i(done_evt[0]), .drain_i(drain_done[0]),
      .state_o(st[0])
   );

   heap_bank_fsm u_bank1 (
      .clk_i(clk), .rst_i(rst),
      .first_wr_i(wr_evt[1]), .last_wr_i(last_evt[1]),
      .start_i(start_evt[1]), .done_i(done_evt[1]), .drain_i(drain_done[1]),
      .state_o(st[1])
   );

   // Edge detector, fill pointer, bank select and registered RAM/engine outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_q         <= 1'b0;
         ptr_q        <= '0;
         fill_bank_q  <= 1'b0;
         first_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_bank_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         sort_start_q <= 1'b0;
         sort_bank_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         fs_q         <= fs;
         ptr_q        <= ptr_d;
         fill_bank_q  <= fill_bank_d;
         first_q      <= first_d;
         wr_en_q      <= do_wr;
         if (do_wr) begin
            wr_bank_q <= fill_bank_q;
            wr_addr_q <= ptr_q;
            wr_data_q <= data_in;
         end
         sort_start_q <= start_any;
         if (start_any) sort_bank_q <= pick;
         if (do_drop)   overrun_q   <= 1'b1;
      end
   end

`ifdef HEAP_SCHED_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   // Saturating count of samples lost to a busy fill bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                drop_cnt_q <= '0;
      else if (do_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

   assign wr_en      = wr_en_q;
   assign wr_bank    = wr_bank_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign sort_start = sort_start_q;
   assign sort_bank  = sort_bank_q;
   assign bank_ready = {st[1] == BS_SORTED, st[0] == BS_SORTED};
   assign fill_bank  = fill_bank_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_heap_pingpong_sched.sv
// Bench for heap_pingpong_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_heap_pingpong_sched;

   localparam int LEVEL = 2;
   localparam int DW    = 32;
   localparam int N     = 7;
   localparam int AW    = 3;
`ifdef HEAP_SCHED_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif
   localparam int ST_EMPTY = 0, ST_FILLING = 1, ST_FULL = 2, ST_SORTING = 3, ST_SORTED = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          fs = 1'b0, en_rec_in = 1'b0, sort_done = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [1:0]    drain_done = '0;
   logic          wr_en, wr_bank, sort_start, sort_bank, fill_bank, overrun;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    bank_ready;
   logic [15:0]   drop_cnt;

   heap_pingpong_sched #(.LEVEL(LEVEL), .DW(DW)) dut (
      .clk(clk), .rst(rst), .fs(fs), .en_rec_in(en_rec_in), .data_in(data_in),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .sort_start(sort_start), .sort_bank(sort_bank), .sort_done(sort_done),
      .drain_done(drain_done), .bank_ready(bank_ready), .fill_bank(fill_bank),
      .overrun(overrun), .drop_cnt(drop_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_st[2];
   int            m_ptr, m_fill, m_first, m_wr_bank, m_wr_addr, m_sbank, m_drop;
   bit            m_fs_prev, m_wr_en, m_start, m_over;
   logic [DW-1:0] m_wr_data;
   logic [AW+DW:0] exp_q[$];
   logic [AW+DW:0] sb_e;

   task automatic model_reset();
      m_st[0] = ST_EMPTY; m_st[1] = ST_EMPTY;
      m_ptr = 0; m_fill = 0; m_first = 0; m_wr_bank = 0; m_wr_addr = 0;
      m_sbank = 0; m_drop = 0; m_fs_prev = 0; m_wr_en = 0; m_start = 0;
      m_over = 0; m_wr_data = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int nxt[2];
      int o, pick, first_n, fill_n;
      bit rise, busy, f0, f1;
      nxt[0] = m_st[0]; nxt[1] = m_st[1];
      first_n = m_first; fill_n = m_fill;
      rise = fs && !m_fs_prev;
      m_fs_prev = fs;
      m_wr_en = 0; m_start = 0;
      o = 1 - m_fill;
      if (rise && en_rec_in) begin
         if (m_st[m_fill] == ST_EMPTY || m_st[m_fill] == ST_FILLING) begin
            m_wr_en = 1; m_wr_bank = m_fill; m_wr_addr = m_ptr; m_wr_data = data_in;
            exp_q.push_back({m_fill[0], m_ptr[AW-1:0], data_in});
            if (m_ptr == N - 1) begin
               nxt[m_fill] = ST_FULL;
               m_ptr = 0;
               if (m_st[o] != ST_FULL) first_n = m_fill;
               if (m_st[o] == ST_EMPTY || (m_st[o] == ST_SORTED && drain_done[o])) fill_n = o;
            end else begin
               nxt[m_fill] = ST_FILLING;
               m_ptr++;
            end
         end else begin
            m_over = 1;
            if (m_drop < 65535) m_drop++;
         end
      end
      busy = (m_st[0] == ST_SORTING) || (m_st[1] == ST_SORTING);
      f0 = (m_st[0] == ST_FULL);
      f1 = (m_st[1] == ST_FULL);
      if (!busy && (f0 || f1)) begin
         pick = (f0 && f1) ? m_first : (f1 ? 1 : 0);
         nxt[pick] = ST_SORTING;
         m_start = 1; m_sbank = pick;
      end
      for (int b = 0; b < 2; b++) begin
         if (sort_done && m_st[b] == ST_SORTING) nxt[b] = ST_SORTED;
         if (drain_done[b] && m_st[b] == ST_SORTED) nxt[b] = ST_EMPTY;
      end
      m_st[0] = nxt[0]; m_st[1] = nxt[1];
      m_first = first_n; m_fill = fill_n;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("wr_en", wr_en, m_wr_en);
         if (wr_en && exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            check("wr_txn", {wr_bank, wr_addr, wr_data}, sb_e);
         end
         check("wr_bank", wr_bank, m_wr_bank);
         check("wr_addr", wr_addr, m_wr_addr);
         check("wr_data", wr_data, m_wr_data);
         check("sort_start", sort_start, m_start);
         check("sort_bank", sort_bank, m_sbank);
         check("bank_ready", bank_ready, {m_st[1] == ST_SORTED, m_st[0] == ST_SORTED});
         check("fill_bank", fill_bank, m_fill);
         check("overrun", overrun, m_over);
         check("drop_cnt", drop_cnt, DROP_EN ? m_drop : 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise fs for one cycle; returns just after the capturing edge.
   task automatic sample(input logic [DW-1:0] d, input logic [1:0] drn);
      fs = 1'b1; data_in = d; drain_done = drn;
      tick();
      fs = 1'b0; drain_done = 2'b00;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit got;
      repeat (3) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      check("rst_wr_en", wr_en, 0);
      check("rst_fill_bank", fill_bank, 0);
      check("rst_bank_ready", bank_ready, 0);
      check("rst_sort_start", sort_start, 0);
      rst = 1'b0; en_rec_in = 1'b1;
      tick();

      // First bank fill: addresses 0..6 in bank 0.
      for (int i = 0; i < 7; i++) begin
         sample(DW'(i + 1), 2'b00);
         check("t1_wr_en", wr_en, 1);
         check("t1_wr_addr", wr_addr, i);
         check("t1_wr_bank", wr_bank, 0);
         check("t1_wr_data", wr_data, i + 1);
         tick();
      end
      check("t1_sort_start", sort_start, 1);
      check("t1_sort_bank", sort_bank, 0);
      check("t1_fill_bank", fill_bank, 1);
      tick();
      check("t1_start_width", sort_start, 0);

      // Engine answers 20 cycles after start.
      repeat (18) tick();
      sort_done = 1'b1; tick(); sort_done = 1'b0;
      check("t2_bank_ready", bank_ready, 2'b01);

      for (int i = 0; i < 7; i++) begin
         sample(DW'(100 + i), 2'b00);
         check("t2_wr_bank", wr_bank, 1);
         check("t2_wr_addr", wr_addr, i);
         tick();
      end
      check("t2_fill_bank", fill_bank, 1);
      check("t2_sort_bank", sort_bank, 1);

      // Both banks occupied: next sample is dropped.
      sample(DW'(999), 2'b00);
      check("t3_wr_en", wr_en, 0);
      check("t3_overrun", overrun, 1);
      check("t3_drop_cnt", drop_cnt, DROP_EN ? 1 : 0);
      tick();

      // Fresh start for the drain bypass scenario.
      rst = 1'b1; tick();
      check("rstb_overrun", overrun, 0);
      check("rstb_bank_ready", bank_ready, 0);
      rst = 1'b0; tick();
      for (int i = 0; i < 7; i++) begin sample(DW'(200 + i), 2'b00); tick(); end
      tick();
      sort_done = 1'b1; tick(); sort_done = 1'b0;
      for (int i = 0; i < 6; i++) begin sample(DW'(300 + i), 2'b00); tick(); end
      sample(DW'(306), 2'b01);
      check("t4_wr_bank", wr_bank, 1);
      check("t4_wr_addr", wr_addr, 6);
      check("t4_fill_bank", fill_bank, 0);
      check("t4_bank_ready", bank_ready, 0);
      tick();
      sample(DW'(400), 2'b00);
      check("t4_next_wr_en", wr_en, 1);
      check("t4_next_bank", wr_bank, 0);
      check("t4_next_addr", wr_addr, 0);
      check("t4_no_overrun", overrun, 0);
      tick();

      // Recording disabled after four writes: pointer holds.
      for (int i = 1; i < 4; i++) begin sample(DW'(400 + i), 2'b00); tick(); end
      en_rec_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample(DW'(500 + i), 2'b00);
         check("t5_wr_en", wr_en, 0);
         check("t5_wr_addr", wr_addr, 3);
         tick();
      end
      en_rec_in = 1'b1;
      sample(DW'(600), 2'b00);
      check("t5_resume_en", wr_en, 1);
      check("t5_resume_addr", wr_addr, 4);
      tick();

      // Finish bank 0, let it reach the engine, then reset mid-sort.
      sample(DW'(601), 2'b00); tick();
      sample(DW'(602), 2'b00); tick();
      sort_done = 1'b1; tick(); sort_done = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         if (sort_start) got = 1'b1;
         else tick();
      end
      check("t6_start_seen", got, 1);
      check("t6_sort_bank", sort_bank, 0);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_wr_en", wr_en, 0);
      check("t6_rst_wr_addr", wr_addr, 0);
      check("t6_rst_wr_data", wr_data, 0);
      check("t6_rst_sort_bank", sort_bank, 0);
      check("t6_rst_bank_ready", bank_ready, 0);
      check("t6_rst_overrun", overrun, 0);
      check("t6_rst_fill_bank", fill_bank, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sort_done = 1'b1; tick(); sort_done = 1'b0;
      check("t6_done_ignored", bank_ready, 0);
      tick();
      check("t6_no_start", sort_start, 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         fs         = 1'($urandom_range(0, 1));
         en_rec_in  = ($urandom_range(0, 7) != 0);
         data_in    = $urandom;
         sort_done  = ($urandom_range(0, 5) == 0);
         drain_done = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         if ($urandom_range(0, 799) == 0) begin
            rst = 1'b1; #2 rst = 1'b0;
         end
         tick();
      end
      fs = 1'b0; sort_done = 1'b0; drain_done = 2'b00;
      tick();
      check("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
